// File: rtl/mem_copier_pkg.sv
// mem_copier shared types: FSM states and command mode encodings.
// Imported by the block-move engine.
package mem_copier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    FILL,
    DONE
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copier.sv
// Block-move engine: forward copy or constant fill over a ram port pair.
// RAM-side outputs decode from registered state only.
module mem_copier
  import mem_copier_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [DATA_WIDTH-1:0] fill,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_ar,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_aw,
  output logic [DATA_WIDTH-1:0] ram_x,
  input  logic [DATA_WIDTH-1:0] ram_y
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, len_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [ADDR_WIDTH-1:0] ar_q, aw_q;

  logic                  in_copy, in_fill;
  logic                  copy_we;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] rd_off;

  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d = '0;
          if (len == '0)
            state_d = DONE;
          else if (mode == MODE_FILL)
            state_d = FILL;
          else
            state_d = COPY;
        end
      end
      COPY: begin
        if (abort || k_q == len_q)
          state_d = DONE;
        else
          k_d = k_q + ONE;
      end
      FILL: begin
        if (abort || k_q == len_q - ONE)
          state_d = DONE;
        else
          k_d = k_q + ONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
      ar_q   <= '0;
      aw_q   <= '0;
    end else begin
      if (accept) begin
        src_q  <= src;
        dst_q  <= dst;
        len_q  <= len;
        fill_q <= fill;
      end
      ar_q <= ram_ar;
      aw_q <= ram_aw;
    end
  end

  // The drain cycle (k == len) re-reads the last address so ram_y stays driven.
  assign in_copy = (state_q == COPY);
  assign in_fill = (state_q == FILL);
  assign copy_we = in_copy && (k_q != '0);
  assign rd_off  = (k_q == len_q) ? len_q - ONE : k_q;

  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    ram_re = in_copy;
    ram_we = copy_we || in_fill;
    ram_ar = in_copy ? src_q + rd_off : ar_q;
    ram_aw = aw_q;
    ram_x  = '0;
    if (copy_we) begin
      ram_aw = dst_q + k_q - ONE;
      ram_x  = ram_y;
    end else if (in_fill) begin
      ram_aw = dst_q + k_q;
      ram_x  = fill_q;
    end
  end

endmodule
